// File: rtl/spi_burst_ctrl.sv
// ---------------------------------------------------------------------------
// spi_burst_ctrl
// Sequences multi-byte SPI transactions in front of spi_master. Each host byte
// is presented to spi_master through its data_send/data_valid edge-trigger
// interface. The controller waits for both completion pulses, returns the
// received byte, and then holds data_valid low for a guard gap before it
// fetches the next byte. A per-byte timeout aborts a stalled burst.
//
// Ports
//   clk, rst_n                 : system clock, asynchronous active-low reset
//   start, len                 : burst request (sampled only in IDLE) and byte count
//   tx_data, tx_valid, tx_ready: host TX byte stream (tx_ready high only in FETCH)
//   rx_data, rx_valid          : received byte with one-cycle strobe
//   busy, done, err, byte_cnt  : burst status
//   spi_data_send/valid        : to spi_master data_send / data_valid
//   spi_send/recv_completed    : completion pulses from spi_master
//   spi_data_recv              : received byte from spi_master
// ---------------------------------------------------------------------------
module spi_burst_ctrl #(
    parameter int MAX_LEN    = 16,
    parameter int LEN_W      = 5,
    parameter int GAP_CYCLES = 2,
    parameter int TIMEOUT    = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic [7:0]       tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic [7:0]       rx_data,
    output logic             rx_valid,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [LEN_W-1:0] byte_cnt,
    output logic [7:0]       spi_data_send,
    output logic             spi_data_valid,
    input  logic             spi_send_completed,
    input  logic             spi_recv_completed,
    input  logic [7:0]       spi_data_recv
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_GAP   = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam int TMO_W = ($clog2(TIMEOUT) > 0) ? $clog2(TIMEOUT) : 1;
    localparam int GAP_W = ($clog2(GAP_CYCLES + 1) > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    logic [2:0]       state_reg;
    logic [LEN_W-1:0] len_reg;
    logic [LEN_W-1:0] byte_cnt_reg;
    logic [TMO_W-1:0] tmo_cnt_reg;
    logic [GAP_W-1:0] gap_cnt_reg;
    logic             send_seen_reg;
    logic             recv_seen_reg;
    logic [7:0]       rx_data_reg;
    logic             rx_valid_reg;
    logic             err_reg;
    logic [7:0]       spi_data_send_reg;
    logic             spi_data_valid_reg;

    // A completion pulse arriving this cycle counts as already seen, so a
    // byte can finish in the same cycle as its last pulse.
    logic send_now;
    logic recv_now;
    logic both_now;

    assign send_now = send_seen_reg | spi_send_completed;
    assign recv_now = recv_seen_reg | spi_recv_completed;
    assign both_now = send_now & recv_now;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg          <= S_IDLE;
            len_reg            <= '0;
            byte_cnt_reg       <= '0;
            tmo_cnt_reg        <= '0;
            gap_cnt_reg        <= '0;
            send_seen_reg      <= 1'b0;
            recv_seen_reg      <= 1'b0;
            rx_data_reg        <= 8'h00;
            rx_valid_reg       <= 1'b0;
            err_reg            <= 1'b0;
            spi_data_send_reg  <= 8'h00;
            spi_data_valid_reg <= 1'b0;
        end else begin
            rx_valid_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        err_reg      <= 1'b0;
                        byte_cnt_reg <= '0;
                        len_reg      <= len;
                        if ((len == '0) || (len > LEN_W'(MAX_LEN))) begin
                            err_reg   <= 1'b1;
                            state_reg <= S_DONE;
                        end else begin
                            state_reg <= S_FETCH;
                        end
                    end
                end
                S_FETCH: begin
                    if (tx_valid) begin
                        spi_data_send_reg  <= tx_data;
                        spi_data_valid_reg <= 1'b1;
                        tmo_cnt_reg        <= '0;
                        send_seen_reg      <= 1'b0;
                        recv_seen_reg      <= 1'b0;
                        state_reg          <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (spi_send_completed) begin
                        send_seen_reg <= 1'b1;
                    end
                    // data_recv is only valid alongside its pulse.
                    if (spi_recv_completed) begin
                        recv_seen_reg <= 1'b1;
                        rx_data_reg   <= spi_data_recv;
                    end
                    if (both_now) begin
                        rx_valid_reg       <= 1'b1;
                        byte_cnt_reg       <= byte_cnt_reg + 1'b1;
                        spi_data_valid_reg <= 1'b0;
                        gap_cnt_reg        <= '0;
                        state_reg          <= S_GAP;
                    end else if (tmo_cnt_reg == TMO_W'(TIMEOUT - 1)) begin
                        spi_data_valid_reg <= 1'b0;
                        err_reg            <= 1'b1;
                        state_reg          <= S_DONE;
                    end else begin
                        tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
                    end
                end
                S_GAP: begin
                    // data_valid stays low here so spi_master always sees a
                    // fresh rising edge for the next byte.
                    if (gap_cnt_reg == GAP_W'(GAP_CYCLES - 1)) begin
                        state_reg <= (byte_cnt_reg < len_reg) ? S_FETCH : S_DONE;
                    end else begin
                        gap_cnt_reg <= gap_cnt_reg + 1'b1;
                    end
                end
                S_DONE: begin
                    state_reg <= S_IDLE;
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    // tx_ready decodes state only, keeping the host handshake loop-free.
    assign tx_ready       = (state_reg == S_FETCH);
    assign busy           = (state_reg != S_IDLE);
    assign done           = (state_reg == S_DONE);
    assign rx_data        = rx_data_reg;
    assign rx_valid       = rx_valid_reg;
    assign err            = err_reg;
    assign byte_cnt       = byte_cnt_reg;
    assign spi_data_send  = spi_data_send_reg;
    assign spi_data_valid = spi_data_valid_reg;

endmodule

// File: tb/tb_spi_burst_ctrl.sv
// ---------------------------------------------------------------------------
// tb_spi_burst_ctrl
// Directed bench for spi_burst_ctrl. A small behavioural spi_master responder
// answers each data_valid rising edge with send/recv completion pulses after
// programmable delays and returns data_send ^ rx_mask. A negedge monitor
// collects received bytes and timing; the initial block runs the directed
// bursts and compares against hand-computed expectations.
// ---------------------------------------------------------------------------
module tb_spi_burst_ctrl;

    localparam int GAP = 2;
    localparam int TMO = 64;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [4:0] len = '0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;
    logic       done;
    logic       err;
    logic [4:0] byte_cnt;
    logic [7:0] spi_data_send;
    logic       spi_data_valid;
    logic       spi_send_completed;
    logic       spi_recv_completed;
    logic [7:0] spi_data_recv;

    spi_burst_ctrl #(
        .MAX_LEN(16), .LEN_W(5), .GAP_CYCLES(GAP), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy), .done(done),
        .err(err), .byte_cnt(byte_cnt),
        .spi_data_send(spi_data_send), .spi_data_valid(spi_data_valid),
        .spi_send_completed(spi_send_completed),
        .spi_recv_completed(spi_recv_completed),
        .spi_data_recv(spi_data_recv)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- spi_master responder ----------------
    int       send_dly = 5;
    int       recv_dly = 5;
    bit       recv_kill = 1'b0;
    logic [7:0] rx_mask = 8'h00;
    logic     m_prev;
    logic     m_active;
    int       m_t;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_prev             <= 1'b0;
            m_active           <= 1'b0;
            m_t                <= 0;
            spi_send_completed <= 1'b0;
            spi_recv_completed <= 1'b0;
            spi_data_recv      <= 8'h00;
        end else begin
            m_prev             <= spi_data_valid;
            spi_send_completed <= 1'b0;
            spi_recv_completed <= 1'b0;
            spi_data_recv      <= ~(spi_data_send ^ rx_mask);
            if (spi_data_valid && !m_prev) begin
                m_active <= 1'b1;
                m_t      <= 0;
            end else if (m_active) begin
                m_t <= m_t + 1;
                if (m_t == send_dly) spi_send_completed <= 1'b1;
                if (m_t == recv_dly && !recv_kill) begin
                    spi_recv_completed <= 1'b1;
                    spi_data_recv      <= spi_data_send ^ rx_mask;
                end
                if (m_t >= send_dly && m_t >= recv_dly) m_active <= 1'b0;
            end
        end
    end

    // ---------------- monitor ----------------
    logic [7:0] rxq[$];
    logic [7:0] expq[$];
    int  done_cnt, rises, low_cnt, high_cnt, last_high, rise_cyc, done_cyc, last_rxv;
    bit  rxv_pend, gap_viol, ready_seen, prev_ready, prev_done, prev_dv;

    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_valid) begin
                rxq.push_back(rx_data);
                chk("dv_low_at_rxv", {31'd0, spi_data_valid}, 32'd0);
                rxv_pend = 1'b1;
                last_rxv = cyc;
            end
            if (tx_ready && !prev_ready && rxv_pend) begin
                chk("gap_to_ready", cyc - last_rxv, GAP);
                rxv_pend = 1'b0;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                if (rxv_pend) chk("done_latency", cyc - last_rxv, GAP);
                rxv_pend = 1'b0;
            end
            if (prev_done) chk("busy_after_done", {30'd0, busy, done}, 32'd0);
            if (tx_ready) ready_seen = 1'b1;
            if (spi_data_valid && !prev_dv) begin
                rises++;
                if (rises > 1 && low_cnt < GAP) gap_viol = 1'b1;
                low_cnt  = 0;
                high_cnt = 0;
                rise_cyc = cyc;
            end
            if (spi_data_valid) high_cnt++; else low_cnt++;
            if (!spi_data_valid && prev_dv) last_high = high_cnt;
            prev_ready = tx_ready;
            prev_done  = done;
            prev_dv    = spi_data_valid;
        end else begin
            prev_ready = 1'b0;
            prev_done  = 1'b0;
            prev_dv    = 1'b0;
            rxv_pend   = 1'b0;
        end
    end

    // ---------------- host tasks ----------------
    task automatic clear_burst();
        rxq.delete();
        expq.delete();
        done_cnt   = 0;
        rises      = 0;
        gap_viol   = 1'b0;
        ready_seen = 1'b0;
        last_high  = 0;
    endtask

    task automatic start_burst(input logic [4:0] n);
        @(negedge clk);
        start = 1'b1;
        len   = n;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 0; i < 2000 && !tx_ready; i++) @(negedge clk);
        chk("tx_ready_seen", {31'd0, tx_ready}, 32'd1);
        tx_valid = 1'b1;
        tx_data  = b;
        expq.push_back(b ^ rx_mask);
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 3000 && !done; i++) @(negedge clk);
        chk("done_seen", {31'd0, done}, 32'd1);
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic check_rx();
        chk("rx_count", rxq.size(), expq.size());
        for (int i = 0; i < expq.size() && i < rxq.size(); i++)
            chk("rx_byte", {24'd0, rxq[i]}, {24'd0, expq[i]});
    endtask

    task automatic check_reset_outputs(input string tag);
        chk(tag, {23'd0, tx_ready, rx_valid, busy, done, err, spi_data_valid,
                  3'd0}, 32'd0);
        chk("rst_rx_data", {24'd0, rx_data}, 32'd0);
        chk("rst_spi_send", {24'd0, spi_data_send}, 32'd0);
        chk("rst_byte_cnt", {27'd0, byte_cnt}, 32'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        bit stall_ok;

        // Reset state
        repeat (2) @(negedge clk);
        check_reset_outputs("rst_flags");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1: single byte loopback, both pulses in the same cycle
        clear_burst();
        rx_mask = 8'h00; send_dly = 5; recv_dly = 5;
        start_burst(5'd1);
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        chk("ready_after_start", {31'd0, tx_ready}, 32'd1);
        send_byte(8'hA5);
        wait_done();
        check_rx();
        chk("t1_done_cnt", done_cnt, 1);
        chk("t1_err", {31'd0, err}, 32'd0);
        chk("t1_byte_cnt", {27'd0, byte_cnt}, 32'd1);
        $display("[TB] burst len=1 loopback rx=%0d bytes", rxq.size());

        // 2: four bytes, send pulse before recv pulse
        clear_burst();
        rx_mask = 8'h5A; send_dly = 3; recv_dly = 7;
        start_burst(5'd4);
        send_byte(8'h01);
        send_byte(8'h80);
        send_byte(8'hFF);
        send_byte(8'h3C);
        wait_done();
        check_rx();
        chk("t2_rises", rises, 4);
        chk("t2_gap_viol", {31'd0, gap_viol}, 32'd0);
        chk("t2_byte_cnt", {27'd0, byte_cnt}, 32'd4);
        chk("t2_err", {31'd0, err}, 32'd0);
        $display("[TB] burst len=4 rises=%0d", rises);

        // 3: host stall before byte 2, recv before send, stray start ignored
        clear_burst();
        send_dly = 6; recv_dly = 2;
        start_burst(5'd3);
        send_byte(8'h11);
        for (int i = 0; i < 2000 && !tx_ready; i++) @(negedge clk);
        stall_ok = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (!tx_ready || spi_data_valid) stall_ok = 1'b0;
            start = (i == 10);
            len   = 5'd0;
            @(negedge clk);
        end
        start = 1'b0;
        chk("t3_stall_hold", {31'd0, stall_ok}, 32'd1);
        send_byte(8'h22);
        send_byte(8'h33);
        wait_done();
        check_rx();
        chk("t3_err", {31'd0, err}, 32'd0);
        chk("t3_byte_cnt", {27'd0, byte_cnt}, 32'd3);
        chk("t3_done_cnt", done_cnt, 1);
        $display("[TB] burst len=3 with stall rx=%0d bytes", rxq.size());

        // 4: len = 0 and len = 17 are rejected
        clear_burst();
        start_burst(5'd0);
        chk("len0_done", {30'd0, done, err}, 32'd3);
        @(negedge clk);
        chk("len0_idle", {29'd0, busy, done, err}, 32'd1);
        repeat (3) @(negedge clk);
        chk("len0_err_hold", {31'd0, err}, 32'd1);
        start_burst(5'd17);
        chk("len17_done", {30'd0, done, err}, 32'd3);
        @(negedge clk);
        chk("len17_ready_never", {31'd0, ready_seen}, 32'd0);
        $display("[TB] len=0 / len=17 rejected err=%0d", err);

        // 5: timeout, recv pulse never arrives
        clear_burst();
        recv_kill = 1'b1; send_dly = 3;
        start_burst(5'd2);
        chk("start_clears_err", {31'd0, err}, 32'd0);
        send_byte(8'h77);
        expq.delete();
        wait_done();
        chk("tmo_err", {31'd0, err}, 32'd1);
        chk("tmo_no_rx", rxq.size(), 0);
        chk("tmo_dv_high", last_high, TMO);
        chk("tmo_latency", done_cyc - rise_cyc, TMO);
        chk("tmo_byte_cnt", {27'd0, byte_cnt}, 32'd0);
        chk("tmo_done_cnt", done_cnt, 1);
        recv_kill = 1'b0;
        $display("[TB] timeout burst err=%0d high=%0d", err, last_high);

        // 6: asynchronous reset mid byte 2 of 4, then a fresh burst
        clear_burst();
        send_dly = 3; recv_dly = 7;
        start_burst(5'd4);
        send_byte(8'hDE);
        send_byte(8'hAD);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("async_rst_flags");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        clear_burst();
        start_burst(5'd1);
        send_byte(8'hC3);
        wait_done();
        check_rx();
        chk("post_rst_err", {31'd0, err}, 32'd0);
        chk("post_rst_byte_cnt", {27'd0, byte_cnt}, 32'd1);
        $display("[TB] post-reset burst rx=%0d bytes", rxq.size());

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

endmodule
